// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave with byte/halfword/word access, optional wait states
// and the two-cycle ERROR response for misaligned or oversized transfers.
module ahb_sram_slave #(
  parameter int addr_w = 14,
  parameter int wait_c = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hsel,
  output logic [31:0] hrdata,
  output logic [1:0]  hresp,
  output logic        hready
);

  localparam int depth = 2 ** addr_w;
  localparam int cnt_w = (wait_c < 2) ? 1 : $clog2(wait_c + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  function automatic logic is_legal(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    is_legal = 1'b1;
      3'd1:    is_legal = !a[0];
      3'd2:    is_legal = (a == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] a);
    case (size)
      3'd0:    lane_en = 4'b0001 << a;
      3'd1:    lane_en = a[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    merge_lanes = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merge_lanes[8*i +: 8] = new_w[8*i +: 8];
    end
  endfunction

  logic [31:0]       mem [depth];
  state_t            state, state_nxt;
  logic [cnt_w-1:0]  cnt, cnt_nxt;
  logic [addr_w+1:0] addr_p1;
  logic              write_p1;
  logic [2:0]        size_p1;
  logic              accept, legal, commit, load_rd, rd_write;
  logic [3:0]        be_p1;
  logic [addr_w+1:0] rd_addr;
  logic [addr_w-1:0] rd_word, wr_word;
  logic [31:0]       rd_data;
  logic              unused_bits;

  // hburst is ignored: every beat is handled as an independent transfer.
  assign unused_bits = ^{hburst, htrans[0], haddr[31:addr_w+2]};

  assign hready  = !((state == S_WAIT) || (state == S_ERR1));
  assign hresp   = ((state == S_ERR1) || (state == S_ERR2)) ? 2'b01 : 2'b00;
  assign accept  = hsel && htrans[1] && hready;
  assign legal   = is_legal(hsize, haddr[1:0]);
  assign commit  = (state == S_DATA) && write_p1;
  assign be_p1   = lane_en(size_p1, addr_p1[1:0]);
  assign wr_word = addr_p1[addr_w+1:2];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_WAIT: begin
        if (cnt == cnt_w'(wait_c)) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + cnt_w'(1);
        end
      end
      S_ERR1: state_nxt = S_ERR2;
      default: begin
        if (accept) begin
          if (!legal) begin
            state_nxt = S_ERR1;
          end else if (wait_c > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = cnt_w'(1);
          end else begin
            state_nxt = S_DATA;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

  // Read word is fetched on the edge that enters DATA; a write committing on the
  // same edge to the same word is forwarded lane by lane.
  always_comb begin
    rd_addr  = haddr[addr_w+1:0];
    rd_write = hwrite;
    if (state == S_WAIT) begin
      rd_addr  = addr_p1;
      rd_write = write_p1;
    end
    rd_word = rd_addr[addr_w+1:2];
    load_rd = (state_nxt == S_DATA) && !rd_write;
    rd_data = mem[rd_word];
    if (commit && (wr_word == rd_word)) rd_data = merge_lanes(rd_data, hwdata, be_p1);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hrdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_rd) hrdata <= rd_data;
    end
  end

  // Address phase -> data phase boundary
  always_ff @(posedge hclk) begin
    if (accept) begin
      addr_p1  <= haddr[addr_w+1:0];
      write_p1 <= hwrite;
      size_p1  <= hsize;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hreset && commit) begin
      for (int i = 0; i < 4; i++) begin
        if (be_p1[i]) mem[wr_word][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (zero-wait and two-wait) against a
// transfer-level model, plus directed literal expectations.
module tb_ahb_sram_slave;

  logic        clk;
  logic        rst_d   [2];
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_d [2];
  logic        write_d [2];
  logic [1:0]  trans_d [2];
  logic [2:0]  size_d  [2];
  logic [2:0]  burst_d [2];
  logic        sel_d   [2];
  logic [31:0] rdata_o [2];
  logic [1:0]  resp_o  [2];
  logic        ready_o [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  ahb_sram_slave #(.addr_w(8), .wait_c(0)) dut0 (
    .hclk(clk), .hreset(rst_d[0]), .haddr(addr_d[0]), .hwdata(wdata_d[0]),
    .hwrite(write_d[0]), .htrans(trans_d[0]), .hsize(size_d[0]), .hburst(burst_d[0]),
    .hsel(sel_d[0]), .hrdata(rdata_o[0]), .hresp(resp_o[0]), .hready(ready_o[0])
  );

  ahb_sram_slave #(.addr_w(8), .wait_c(2)) dut1 (
    .hclk(clk), .hreset(rst_d[1]), .haddr(addr_d[1]), .hwdata(wdata_d[1]),
    .hwrite(write_d[1]), .htrans(trans_d[1]), .hsize(size_d[1]), .hburst(burst_d[1]),
    .hsel(sel_d[1]), .hrdata(rdata_o[1]), .hresp(resp_o[1]), .hready(ready_o[1])
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Transfer-level model: phase kind (0 none, 1 okay, 2 error) plus low cycles left.
  int          ph_m  [2] = '{0, 0};
  int          low_m [2] = '{0, 0};
  logic [31:0] pa_m  [2];
  bit          pw_m  [2];
  int          ps_m  [2];
  logic [31:0] rd_m  [2] = '{32'h0, 32'h0};
  bit   [31:0] mem_m [2][256];

  function automatic bit exp_ready(input int k);
    return (ph_m[k] == 0) || (low_m[k] == 0);
  endfunction

  function automatic logic [1:0] exp_resp(input int k);
    return (ph_m[k] == 2) ? 2'b01 : 2'b00;
  endfunction

  task automatic model_edge(input int k);
    bit rdy;
    int nb;
    int w;
    int lo;
    rdy = exp_ready(k);
    if (rst_d[k]) begin
      ph_m[k] = 0; low_m[k] = 0; rd_m[k] = 32'h0;
      return;
    end
    if (ph_m[k] == 1 && rdy && pw_m[k]) begin
      nb = 1 << ps_m[k];
      w  = int'(pa_m[k][9:2]);
      lo = int'(pa_m[k][1:0]);
      for (int b = 0; b < 4; b++)
        if (b >= lo && b < lo + nb) mem_m[k][w][8*b +: 8] = wdata_d[k][8*b +: 8];
    end
    if (!rdy) begin
      low_m[k] = low_m[k] - 1;
    end else if (sel_d[k] && trans_d[k] >= 2) begin
      nb = 1 << size_d[k];
      if (size_d[k] <= 2 && (addr_d[k] % nb) == 0) begin
        ph_m[k] = 1; low_m[k] = (k == 0) ? 0 : 2;
        pa_m[k] = addr_d[k]; pw_m[k] = write_d[k]; ps_m[k] = int'(size_d[k]);
      end else begin
        ph_m[k] = 2; low_m[k] = 1;
      end
    end else begin
      ph_m[k] = 0;
    end
    if (ph_m[k] == 1 && low_m[k] == 0 && !pw_m[k]) rd_m[k] = mem_m[k][pa_m[k][9:2]];
  endtask

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("model_hready_dut%0d", k), 32'(ready_o[k]), 32'(exp_ready(k)));
        check($sformatf("model_hresp_dut%0d", k), 32'(resp_o[k]), 32'(exp_resp(k)));
        check($sformatf("model_hrdata_dut%0d", k), rdata_o[k], rd_m[k]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    sel_d[k] = 0; trans_d[k] = 2'd0; write_d[k] = 0; size_d[k] = 3'd0;
    addr_d[k] = 32'h0; burst_d[k] = 3'd0;
  endtask

  task automatic addr_ph(input int k, input logic [31:0] a, input logic w, input logic [2:0] s);
    sel_d[k] = 1; trans_d[k] = 2'd2; addr_d[k] = a; write_d[k] = w; size_d[k] = s;
  endtask

  // Single non-pipelined transfer; reports low cycles, final response and read data.
  task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [2:0] s,
                      input logic [31:0] wd, output logic [31:0] rd, output int lows,
                      output logic [1:0] resp);
    addr_ph(k, a, w, s);
    step();
    idle(k);
    wdata_d[k] = wd;
    lows = 0;
    while (ready_o[k] !== 1'b1 && lows < 20) begin
      lows++;
      step();
    end
    if (lows >= 20) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: hready low %0d cycles, expected at most 2", lows);
    end
    rd = rdata_o[k];
    resp = resp_o[k];
    step();
  endtask

  logic [31:0] rd;
  int          lows;
  logic [1:0]  resp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      idle(k);
      wdata_d[k] = 32'h0;
      rst_d[k] = 1;
    end
    step();
    chk_en = 1;
    step();
    step();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset_hready_dut%0d", k), 32'(ready_o[k]), 32'h1);
      check($sformatf("reset_hresp_dut%0d", k), 32'(resp_o[k]), 32'h0);
      check($sformatf("reset_hrdata_dut%0d", k), rdata_o[k], 32'h0);
      rst_d[k] = 0;
    end
    step();

    // Back-to-back write then read of the same word (forwarding path)
    addr_ph(0, 32'h10, 1, 3'd2);
    step();
    addr_ph(0, 32'h10, 0, 3'd2);
    wdata_d[0] = 32'hDEADBEEF;
    check("b2b_write_dphase_hready", 32'(ready_o[0]), 32'h1);
    step();
    idle(0);
    check("b2b_read_hready", 32'(ready_o[0]), 32'h1);
    check("b2b_read_hrdata", rdata_o[0], 32'hDEADBEEF);
    step();

    // Byte and halfword lanes
    xfer(0, 32'h20, 1, 3'd2, 32'h11223344, rd, lows, resp);
    xfer(0, 32'h21, 1, 3'd0, 32'h0000AA00, rd, lows, resp);
    xfer(0, 32'h22, 1, 3'd1, 32'hBBCC0000, rd, lows, resp);
    xfer(0, 32'h20, 0, 3'd2, 32'h0, rd, lows, resp);
    check("lanes_hrdata", rd, 32'hBBCCAA44);
    check("lanes_zero_wait", 32'(lows), 32'd0);

    // Two wait states
    xfer(1, 32'h40, 1, 3'd2, 32'h12345678, rd, lows, resp);
    check("wait_write_lows", 32'(lows), 32'd2);
    xfer(1, 32'h40, 0, 3'd2, 32'h0, rd, lows, resp);
    check("wait_read_lows", 32'(lows), 32'd2);
    check("wait_read_hrdata", rd, 32'h12345678);
    check("wait_read_hresp", 32'(resp), 32'h0);

    // Misaligned word read, then a read accepted during the second error cycle
    xfer(0, 32'h0, 1, 3'd2, 32'hCAFEF00D, rd, lows, resp);
    addr_ph(0, 32'h6, 0, 3'd2);
    step();
    check("err1_hready", 32'(ready_o[0]), 32'h0);
    check("err1_hresp", 32'(resp_o[0]), 32'h1);
    addr_ph(0, 32'h0, 0, 3'd2);
    step();
    check("err2_hready", 32'(ready_o[0]), 32'h1);
    check("err2_hresp", 32'(resp_o[0]), 32'h1);
    step();
    idle(0);
    check("after_err_hresp", 32'(resp_o[0]), 32'h0);
    check("after_err_hrdata", rdata_o[0], 32'hCAFEF00D);
    step();

    // Misaligned halfword write must not touch memory
    xfer(0, 32'h1, 1, 3'd1, 32'hFFFFFFFF, rd, lows, resp);
    check("half_err_hresp", 32'(resp), 32'h1);
    check("half_err_lows", 32'(lows), 32'd1);
    xfer(0, 32'h0, 0, 3'd2, 32'h0, rd, lows, resp);
    check("half_err_mem_kept", rd, 32'hCAFEF00D);

    // IDLE, BUSY and unselected NONSEQ writes are ignored
    addr_ph(0, 32'h0, 1, 3'd2);
    trans_d[0] = 2'd0;
    wdata_d[0] = 32'hFFFFFFFF;
    step();
    check("idle_hready", 32'(ready_o[0]), 32'h1);
    check("idle_hresp", 32'(resp_o[0]), 32'h0);
    trans_d[0] = 2'd1;
    step();
    check("busy_hready", 32'(ready_o[0]), 32'h1);
    trans_d[0] = 2'd2;
    sel_d[0] = 0;
    step();
    check("unsel_hready", 32'(ready_o[0]), 32'h1);
    check("unsel_hresp", 32'(resp_o[0]), 32'h0);
    step();
    idle(0);
    xfer(0, 32'h0, 0, 3'd2, 32'h0, rd, lows, resp);
    check("unsel_mem_kept", rd, 32'hCAFEF00D);

    // Reset during the wait of a write aborts it
    xfer(1, 32'h80, 1, 3'd2, 32'h55AA55AA, rd, lows, resp);
    addr_ph(1, 32'h80, 1, 3'd2);
    step();
    idle(1);
    wdata_d[1] = 32'h0BADF00D;
    check("rst_mid_wait_low", 32'(ready_o[1]), 32'h0);
    rst_d[1] = 1;
    step();
    rst_d[1] = 0;
    check("rst_mid_hready", 32'(ready_o[1]), 32'h1);
    check("rst_mid_hresp", 32'(resp_o[1]), 32'h0);
    check("rst_mid_hrdata", rdata_o[1], 32'h0);
    xfer(1, 32'h80, 0, 3'd2, 32'h0, rd, lows, resp);
    check("rst_mid_mem_kept", rd, 32'h55AA55AA);

    // Address bits above the array alias onto it
    xfer(0, 32'h410, 1, 3'd2, 32'h600DCAFE, rd, lows, resp);
    xfer(0, 32'h10, 0, 3'd2, 32'h0, rd, lows, resp);
    check("alias_hrdata", rd, 32'h600DCAFE);

    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite single-port SRAM slave that attaches to one slave port of the AHB router.
- Consumes the per-slave address-phase and data-phase signals (haddr_s, hwdata_s, hsel_s, ...).
- Returns hrdata_s, hready_s and hresp_s.
- Supports byte, halfword and word access, a configurable number of wait states, and the two-cycle ERROR response for illegal transfers.

Parameters:
addr_w, 14, word-address bits; memory holds 2**addr_w 32-bit words (byte address bits [addr_w+1:2]).
wait_c, 0, wait states inserted in every data phase (0 = zero-wait).

Ports:
hclk  input  1  AHB clock; all logic on its rising edge.
hreset  input  1  synchronous, active-high reset.
haddr  input  32  address (address phase).
hwdata  input  32  write data (data phase).
hwrite  input  1  1 = write, 0 = read.
htrans  input  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
hsize  input  3  0 byte, 1 halfword, 2 word, >2 illegal.
hburst  input  3  accepted and ignored; each beat is an independent transfer.
hsel  input  1  slave select from router.
hrdata  output  32  read data.
hresp  output  2  00 OKAY, 01 ERROR.
hready  output  1  transfer-done / slave ready.

Behaviour:
- Reset (hreset=1 at posedge):
  - hready=1, hresp=00, hrdata=0, FSM=IDLE, wait counter=0, pending write discarded.
  - SRAM contents are not cleared.
  - Reset mid data phase aborts the transfer with no memory update.
- Accept condition at posedge: hsel=1, htrans[1]=1 and hready=1.
  - On accept, register haddr[addr_w+1:0], hwrite and hsize into data-phase registers.
  - IDLE/BUSY, or hsel=0, gets no accept and completes with OKAY zero-wait.
- Legality is checked at accept. Illegal when any of:
  - hsize>2;
  - hsize=1 and haddr[0]=1;
  - hsize=2 and haddr[1:0]!=0.
- FSM states:
  - IDLE: hready=1, hresp=00.
    - Legal accept and wait_c>0 -> WAIT.
    - Legal accept and wait_c=0 -> DATA.
    - Illegal accept -> ERR1.
  - WAIT: hready=0, hresp=00; counter counts 1..wait_c; at count=wait_c -> DATA.
  - DATA: hready=1, hresp=00, completes the transfer.
    - Concurrent legal accept -> WAIT or DATA.
    - Concurrent illegal accept -> ERR1.
    - Otherwise -> IDLE.
  - ERR1: hready=0, hresp=01; -> ERR2.
  - ERR2: hready=1, hresp=01; no memory access; accept is legal here, transitions as from DATA.
- Write:
  - hwdata is sampled at the posedge ending DATA (hready=1).
  - Byte enables: byte -> lane haddr[1:0]; half -> lanes {haddr[1],0} and {haddr[1],1}; word -> all four lanes.
  - Only enabled lanes are updated.
- Read:
  - hrdata carries the full 32-bit word at the registered address while hready=1 in DATA; the master extracts lanes.
  - hrdata holds its last value outside read data phases.
- Zero-wait latency: address phase in cycle N, data/hready=1 in cycle N+1. Back-to-back pipelined accesses sustain 1 transfer per cycle.
- Hazard: a read accepted on the same edge that commits a write to the same word must return the merged new data (write-forwarding per byte lane).
- Address wrap: bits above addr_w+1 are ignored (aliasing); no error for out-of-range address.

Test Plan:
- Reset: hreset=1 for 3 cycles -> hready=1, hresp=00, hrdata=0x00000000.
- Zero-wait word write then read, wait_c=0:
  - Write 0x00000010 <- 0xDEADBEEF, then read 0x00000010 back-to-back.
  - Required: hrdata=0xDEADBEEF in the cycle after the read address phase; hready never low.
- Byte/half writes:
  - Word 0x20 = 0x11223344; byte write 0xAA to 0x21; half write 0xBBCC to 0x22.
  - Read 0x20 -> 0xBBCCAA44.
- Wait states, wait_c=2:
  - Read of 0x40 holding 0x12345678 -> hready low exactly 2 cycles, then hready=1 with hrdata=0x12345678.
- Error:
  - Word read at 0x00000006 -> hresp=01 with hready=0, then hresp=01 with hready=1.
  - Next NONSEQ read of 0x0 accepted in ERR2 completes with OKAY.
  - Halfword write at 0x1 -> memory unchanged.
- Idle/unselected and reset mid-operation:
  - htrans=0, or hsel=0 with htrans=2 -> no access, hready=1, hresp=00.
  - hreset asserted during a WAIT of a write to 0x80 -> hready=1 next cycle; 0x80 keeps its old value.
